// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared LDPC decoder sizing constants and check-node FSM state type.
package ldpc_pkg;
   localparam int LIFTING_FACTOR = 4;
   localparam int LLR_WIDTH      = 4;
   localparam int MAX_DEGREE     = 8;
   localparam int MAG_MAX        = 2 ** (LLR_WIDTH - 1) - 1;
   typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} cnu_state_e;
endpackage

// File: rtl/cnu_lane.sv
// cnu_lane: one lane of the min-sum check node, tracking min1/min2/idx/sign.
module cnu_lane #(
   parameter int LLR_WIDTH = 4,
   parameter int IDX_W     = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 acc,
   input  logic [LLR_WIDTH-1:0] llr,
   input  logic [IDX_W-1:0]     cnt,
   output logic [LLR_WIDTH-2:0] min1,
   output logic [LLR_WIDTH-2:0] min2,
   output logic [IDX_W-1:0]     idx,
   output logic                 sign
);
   logic [LLR_WIDTH-1:0] abs_v;
   logic [LLR_WIDTH-2:0] mag, min1_q, min1_d, min2_q, min2_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 sign_q, sign_d, lt1, lt2;
   assign abs_v = llr[LLR_WIDTH-1] ? (~llr + 1'b1) : llr;
   // Only the most negative code overflows the magnitude range; all-ones is MAG_MAX
   assign mag   = abs_v[LLR_WIDTH-1] ? '1 : abs_v[LLR_WIDTH-2:0];
   assign lt1   = mag < min1_q;
   assign lt2   = mag < min2_q;
   always_comb begin
      min1_d = clr ? '1 : (acc && lt1) ? mag : min1_q;
      min2_d = clr ? '1 : !acc ? min2_q : lt1 ? min1_q : lt2 ? mag : min2_q;
      idx_d  = clr ? '0 : (acc && lt1) ? cnt : idx_q;
      sign_d = clr ? 1'b0 : sign_q ^ (acc & llr[LLR_WIDTH-1]);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         min1_q <= '1;
         min2_q <= '1;
         idx_q  <= '0;
         sign_q <= 1'b0;
      end else begin
         min1_q <= min1_d;
         min2_q <= min2_d;
         idx_q  <= idx_d;
         sign_q <= sign_d;
      end
   end
   assign min1 = min1_q;
   assign min2 = min2_q;
   assign idx  = idx_q;
   assign sign = sign_q;
endmodule

// File: rtl/cnu_minsum.sv
// cnu_minsum: Z-lane min-sum check node unit; accumulates one row of beats, then
// holds the per-lane min1/min2/idx/sign result until the consumer takes it.
module cnu_minsum #(
   parameter int LIFTING_FACTOR = ldpc_pkg::LIFTING_FACTOR,
   parameter int LLR_WIDTH      = ldpc_pkg::LLR_WIDTH,
   parameter int MAX_DEGREE     = ldpc_pkg::MAX_DEGREE,
   localparam int IDX_W         = (MAX_DEGREE > 1) ? $clog2(MAX_DEGREE) : 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic                               in_last,
   input  logic [LIFTING_FACTOR*LLR_WIDTH-1:0] in_llr,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [LIFTING_FACTOR*(LLR_WIDTH-1)-1:0] out_min1,
   output logic [LIFTING_FACTOR*(LLR_WIDTH-1)-1:0] out_min2,
   output logic [LIFTING_FACTOR*IDX_W-1:0]     out_idx,
   output logic [LIFTING_FACTOR-1:0]           out_sign,
   output logic [IDX_W:0]                      out_degree,
   output logic                               out_overflow
);
   import ldpc_pkg::*;
   localparam int Z = LIFTING_FACTOR;
   localparam int W = LLR_WIDTH;
   cnu_state_e   state_q, state_d;
   logic [IDX_W:0] cnt_q, cnt_d;
   logic         ovf_q, ovf_d, acc, clr, at_max;
   always_comb begin
      in_ready  = state_q == ST_ACCUM;
      out_valid = state_q == ST_HOLD;
      acc       = in_valid && in_ready;
      clr       = out_valid && out_ready;
      at_max    = cnt_q == (IDX_W + 1)'(MAX_DEGREE - 1);
      state_d   = clr ? ST_ACCUM : (acc && (in_last || at_max)) ? ST_HOLD : state_q;
      cnt_d     = clr ? '0 : acc ? cnt_q + 1'b1 : cnt_q;
      ovf_d     = clr ? 1'b0 : (acc && at_max && !in_last) ? 1'b1 : ovf_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_ACCUM;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end
   for (genvar g = 0; g < Z; g++) begin : g_lane
      cnu_lane #(.LLR_WIDTH(W), .IDX_W(IDX_W)) u_lane (
         .clk  (clk),
         .rst_n(rst_n),
         .clr  (clr),
         .acc  (acc),
         .llr  (in_llr[g*W +: W]),
         .cnt  (cnt_q[IDX_W-1:0]),
         .min1 (out_min1[g*(W-1) +: W-1]),
         .min2 (out_min2[g*(W-1) +: W-1]),
         .idx  (out_idx[g*IDX_W +: IDX_W]),
         .sign (out_sign[g])
      );
   end
   assign out_degree   = cnt_q;
   assign out_overflow = ovf_q;
endmodule

// File: tb/tb_cnu_minsum.sv
// tb_cnu_minsum: table-driven row vectors plus stall, overflow and reset sequences.
module tb_cnu_minsum;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, in_last, out_valid, out_ready, out_overflow;
   logic [15:0] in_llr;
   logic [11:0] out_min1, out_min2, out_idx;
   logic [3:0]  out_sign, out_degree;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0][15:0] beats;
      int               n;
      bit               last;
      logic [11:0]      m1, m2, ix;
      logic [3:0]       s, d;
      bit               o;
   } row_t;
   row_t rows[5];

   cnu_minsum dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in_llr(in_llr), .out_valid(out_valid), .out_ready(out_ready), .out_min1(out_min1),
      .out_min2(out_min2), .out_idx(out_idx), .out_sign(out_sign), .out_degree(out_degree),
      .out_overflow(out_overflow)
   );

   always #5 clk = ~clk;

   function automatic row_t mk(input logic [127:0] b, input int n, input bit last,
                               input logic [11:0] m1, input logic [11:0] m2, input logic [11:0] ix,
                               input logic [3:0] s, input logic [3:0] d, input bit o);
      row_t r;
      r.beats = b; r.n = n; r.last = last; r.m1 = m1; r.m2 = m2; r.ix = ix;
      r.s = s; r.d = d; r.o = o;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_min1"}, out_min1, 12'hfff);
      chk({tag, "_min2"}, out_min2, 12'hfff);
      chk({tag, "_idx"}, out_idx, 0);
      chk({tag, "_sign"}, out_sign, 0);
      chk({tag, "_degree"}, out_degree, 0);
      chk({tag, "_overflow"}, out_overflow, 0);
   endtask

   task automatic chk_result(input row_t r, input string tag);
      chk({tag, "_out_valid"}, out_valid, 1);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_min1"}, out_min1, r.m1);
      chk({tag, "_min2"}, out_min2, r.m2);
      chk({tag, "_idx"}, out_idx, r.ix);
      chk({tag, "_sign"}, out_sign, r.s);
      chk({tag, "_degree"}, out_degree, r.d);
      chk({tag, "_overflow"}, out_overflow, r.o);
   endtask

   task automatic run_row(input row_t r, input string tag);
      for (int k = 0; k < r.n; k++) begin
         in_valid = 1'b1;
         in_llr   = r.beats[k];
         in_last  = r.last && (k == r.n - 1);
         chk({tag, "_accum_ready"}, in_ready, 1);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk_result(r, tag);
   endtask

   task automatic release_row(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk_idle({tag, "_rel"});
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rows[0] = mk({16'h0, 16'h0, 16'h0, 16'h0, 16'hF706, 16'hF702, 16'hF70B, 16'hF703}, 4, 1,
                   {3'd1, 3'd7, 3'd0, 3'd2}, {3'd1, 3'd7, 3'd0, 3'd3}, {3'd0, 3'd0, 3'd0, 3'd2},
                   4'b0001, 4'd4, 0);
      rows[1] = mk({96'h0, 16'h0D4E, 16'h0581}, 2, 1,
                   {3'd0, 3'd3, 3'd4, 3'd1}, {3'd0, 3'd5, 3'd7, 3'd2}, {3'd0, 3'd1, 3'd1, 3'd0},
                   4'b0111, 4'd2, 0);
      rows[2] = mk({112'h0, 16'h1C29}, 1, 1,
                   {3'd1, 3'd4, 3'd2, 3'd7}, {3'd7, 3'd7, 3'd7, 3'd7}, 12'h0,
                   4'b0101, 4'd1, 0);
      rows[3] = mk({80'h0, 16'hC5D4, 16'h43E5, 16'h43F6}, 3, 1,
                   {3'd4, 3'd3, 3'd1, 3'd4}, {3'd4, 3'd3, 3'd2, 3'd5}, {3'd0, 3'd0, 3'd0, 3'd2},
                   4'b1010, 4'd3, 0);
      rows[4] = mk({16'h5F20, 16'h5F21, 16'hAF22, 16'h5F23, 16'h0F24, 16'h5F25, 16'h5F26, 16'h5F27},
                   8, 0,
                   {3'd0, 3'd1, 3'd2, 3'd0}, {3'd5, 3'd1, 3'd2, 3'd1}, {3'd3, 3'd0, 3'd0, 3'd7},
                   4'b1000, 4'd8, 1);
      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_llr = '0; out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      chk_idle("reset");

      for (int i = 0; i < 5; i++) begin
         run_row(rows[i], $sformatf("row%0d", i));
         if (i == 0) begin
            // Stall in HOLD with junk beats offered; nothing may move or be taken
            in_valid = 1'b1; in_last = 1'b1; in_llr = 16'h1111;
            for (int c = 0; c < 5; c++) begin
               tick();
               chk_result(rows[0], $sformatf("stall%0d", c));
            end
         end
         release_row($sformatf("row%0d", i));
      end
      run_row(rows[2], "after_ovf");
      release_row("after_ovf");

      in_valid = 1'b1; in_last = 1'b0;
      in_llr = rows[0].beats[0]; tick();
      in_llr = rows[0].beats[1]; tick();
      in_valid = 1'b0;
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk_idle("rst_midrow");
      run_row(rows[1], "post_rst");
      release_row("post_rst");

      run_row(rows[3], "pre_hold_rst");
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk_idle("rst_hold");
      run_row(rows[2], "post_hold_rst");
      release_row("post_hold_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cnu_minsum.md
CNU_MINSUM -- requirements
Module: cnu_minsum

Interface
REQ-001 The block SHALL take parameter LIFTING_FACTOR, default 4, the number of parallel lanes Z (one per shift-network output).
REQ-002 The block SHALL take parameter LLR_WIDTH, default 4, the two's-complement message width W.
REQ-003 The block SHALL take parameter MAX_DEGREE, default 8, the maximum check-row degree D; IDX_W = clog2(D).
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  one Z-lane message beat is presented.
REQ-007 in_ready  output  1  block accepts a beat this cycle.
REQ-008 in_last  input  1  the presented beat is the final edge of the row.
REQ-009 in_llr  input  Z*W  lane i = in_llr[i*W +: W], already cyclically shifted.
REQ-010 out_valid  output  1  row result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_min1  output  Z*(W-1)  per-lane smallest magnitude.
REQ-013 out_min2  output  Z*(W-1)  per-lane second-smallest magnitude.
REQ-014 out_idx  output  Z*IDX_W  per-lane edge index of min1.
REQ-015 out_sign  output  Z  per-lane XOR of all input sign bits.
REQ-016 out_degree  output  IDX_W+1  number of beats accepted for the row.
REQ-017 out_overflow  output  1  row was force-terminated at MAX_DEGREE beats without in_last.

Function
REQ-018 The block SHALL run a two-state FSM: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-019 A beat SHALL be accepted only when in_valid && in_ready; all other cycles leave accumulators unchanged.
REQ-020 Per-lane magnitude SHALL be |llr| saturated to MAG_MAX = 2^(W-1)-1 (-8 maps to 7 for W=4).
REQ-021 On accept, if mag < min1: min2<=min1, min1<=mag, idx<=edge count; else if mag < min2: min2<=mag; ties with min1 SHALL go to min2, keeping the earlier index.
REQ-022 On accept, sign SHALL toggle by the lane's MSB and the edge counter SHALL increment.
REQ-023 An accepted beat with in_last=1 SHALL move ACCUM->HOLD; results SHALL appear on the outputs the next cycle (latency 1).
REQ-024 An accepted beat that is the MAX_DEGREE-th beat with in_last=0 SHALL move to HOLD with out_overflow=1; a following beat starts a new row.
REQ-025 Outputs SHALL stay stable in HOLD until out_ready=1; that cycle SHALL clear accumulators (min1=min2=MAG_MAX, idx=0, sign=0, count=0, overflow=0) and return to ACCUM.
REQ-026 No beat SHALL be accepted in the HOLD->ACCUM transition cycle (in_ready low throughout HOLD).
REQ-027 A degree-1 row SHALL report min2=MAG_MAX.
REQ-028 in_valid, in_last and in_llr SHALL be ignored when not accepted.

Reset
REQ-029 While rst_n=0 at a clock edge the FSM SHALL enter ACCUM and all accumulators SHALL take the cleared values of REQ-025.
REQ-030 After reset: in_ready=1, out_valid=0, out_min1=out_min2=MAG_MAX, out_idx=0, out_sign=0, out_degree=0, out_overflow=0.
REQ-031 Reset asserted mid-row or in HOLD SHALL discard the partial or pending result with no output handshake.

Structure
REQ-032 LIFTING_FACTOR, LLR_WIDTH, MAX_DEGREE, MAG_MAX and the FSM state enum SHALL live in shared package ldpc_pkg.
REQ-033 The per-lane min1/min2/idx/sign datapath SHALL be sub-module cnu_lane, instantiated Z times under one shared FSM and edge counter.

Verification
REQ-034 Lane0 beats 3,-5,2,6(last) -> min1=2, min2=3, idx=2, sign=1, degree=4, one cycle after last.
REQ-035 Lane1 beats -8,4(last) -> min1=4, min2=7, idx=1, sign=1; single beat 2(last) -> min1=2, min2=7.
REQ-036 Lane2 beats 3,3,5(last) -> min1=3, idx=0, min2=3.
REQ-037 8 beats, in_last never set -> HOLD after 8th beat, out_overflow=1, degree=8; 9th beat begins new row.
REQ-038 out_ready held 0 for 5 cycles in HOLD -> outputs constant, in_ready=0; then out_ready=1 -> next cycle in_ready=1, accumulators cleared.
REQ-039 rst_n=0 for one cycle after 2 beats -> reset values; next row with fresh beats reports only those beats.
